// File: rtl/regfile_scan_pkg.sv
// Shared types and constants for the register file scan controller.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

package regfile_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FREEZE,
        LOAD,
        SHIFT,
        STORE,
        NEXT,
        DONE
    } scan_state_t;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    localparam logic CMD_DUMP = 1'b0;
    localparam logic CMD_LOAD = 1'b1;

    // One MSB-first CRC-16-CCITT step for a single serial bit.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
        logic fb;
        fb = crc[15] ^ din;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/scan_crc16.sv
// Bit-serial CRC-16-CCITT over the scan stream; only built when REGFILE_SCAN_CRC_EN is defined.
`ifdef REGFILE_SCAN_CRC_EN
module scan_crc16
    import regfile_scan_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            crc <= '0;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc16_step(crc, din);
        end
    end

endmodule
`endif

// File: rtl/regfile_scan_ctrl.sv
// Freezes the pipeline and scans a register file word by word to or from the debug host.
// Define REGFILE_SCAN_CRC_EN to add a CRC-16-CCITT over the bits driven on sIn.
module regfile_scan_ctrl
    import regfile_scan_pkg::*;
#(
    parameter int SIZE           = 16,
    parameter int WIDTH          = `WORD_LENGTH,
    parameter int FREEZE_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmdValid,
    output logic             cmdReady,
    input  logic             cmdLoad,
    input  logic             wrValid,
    output logic             wrReady,
    input  logic [WIDTH-1:0] wrData,
    output logic             rdValid,
    input  logic             rdReady,
    output logic [WIDTH-1:0] rdData,
    output logic             freezeReq,
    input  logic             freezeAck,
    output logic             sEnable,
    output logic             sIn,
    input  logic             sOut,
    output logic             busy,
    output logic             error,
    output logic [15:0]      crc
);

    localparam int BW = $clog2(WIDTH) + 1;
    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int TW = $clog2(FREEZE_TIMEOUT + 1);

    localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [AW-1:0] LAST_WORD = AW'(SIZE - 1);
    localparam logic [TW-1:0] TIMEOUT   = TW'(FREEZE_TIMEOUT);

    scan_state_t      state;
    logic             load_mode;
    logic             abort;
    logic [BW-1:0]    bit_cnt;
    logic [AW-1:0]    word_cnt;
    logic [TW-1:0]    timer;
    logic [WIDTH-1:0] shreg;

    // NOTE: sIn must be combinational: the register file captures it on the same edge that
    // consumes the current sOut bit, so a registered copy would arrive one bit late.
    assign sIn = sEnable & ((load_mode == CMD_LOAD) ? shreg[0] : sOut);

    always_ff @(posedge clk) begin
        // NOTE: all state and registered outputs use non-blocking assignments so every
        // branch below sees the pre-edge values; reset is synchronous and covers each one.
        if (rst) begin
            state     <= IDLE;
            load_mode <= CMD_DUMP;
            abort     <= 1'b0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            timer     <= '0;
            shreg     <= '0;
            cmdReady  <= 1'b1;
            wrReady   <= 1'b0;
            rdValid   <= 1'b0;
            rdData    <= '0;
            freezeReq <= 1'b0;
            sEnable   <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmdValid) begin
                    load_mode <= cmdLoad;
                    abort     <= 1'b0;
                    error     <= 1'b0;
                    timer     <= '0;
                    bit_cnt   <= '0;
                    word_cnt  <= '0;
                    cmdReady  <= 1'b0;
                    busy      <= 1'b1;
                    freezeReq <= 1'b1;
                    state     <= FREEZE;
                end
                FREEZE: if (freezeAck) begin
                    if (load_mode == CMD_LOAD) begin
                        wrReady <= 1'b1;
                        state   <= LOAD;
                    end else begin
                        sEnable <= 1'b1;
                        state   <= SHIFT;
                    end
                end else if (timer == TIMEOUT) begin
                    error     <= 1'b1;
                    freezeReq <= 1'b0;
                    busy      <= 1'b0;
                    cmdReady  <= 1'b1;
                    state     <= IDLE;
                end else begin
                    timer <= timer + 1'b1;
                end
                LOAD: if (wrValid) begin
                    shreg   <= wrData;
                    wrReady <= 1'b0;
                    sEnable <= 1'b1;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (load_mode == CMD_DUMP) begin
                        shreg <= {sOut, shreg[WIDTH-1:1]};
                    end else begin
                        shreg <= shreg >> 1;
                    end
                    if (bit_cnt == LAST_BIT) begin
                        sEnable <= 1'b0;
                        if (load_mode == CMD_DUMP) begin
                            rdData  <= {sOut, shreg[WIDTH-1:1]};
                            rdValid <= 1'b1;
                            state   <= STORE;
                        end else begin
                            state <= NEXT;
                        end
                    end
                end
                STORE: if (rdReady) begin
                    rdValid <= 1'b0;
                    state   <= NEXT;
                end
                NEXT: begin
                    bit_cnt <= '0;
                    // A lost freeze ends the scan after the word that was in flight.
                    if (word_cnt == LAST_WORD || abort || !freezeAck) begin
                        state <= DONE;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                        if (load_mode == CMD_LOAD) begin
                            wrReady <= 1'b1;
                            state   <= LOAD;
                        end else begin
                            sEnable <= 1'b1;
                            state   <= SHIFT;
                        end
                    end
                end
                DONE: begin
                    word_cnt  <= '0;
                    freezeReq <= 1'b0;
                    busy      <= 1'b0;
                    cmdReady  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if ((state inside {LOAD, SHIFT, STORE, NEXT}) && !freezeAck) begin
                abort <= 1'b1;
                error <= 1'b1;
            end
        end
    end

`ifdef REGFILE_SCAN_CRC_EN
    logic cmd_accept;
    assign cmd_accept = (state == IDLE) && cmdValid;

    scan_crc16 u_crc (
        .clk   (clk),
        .rst   (rst),
        .clear (cmd_accept),
        .en    (sEnable),
        .din   (sIn),
        .crc   (crc)
    );
`else
    assign crc = '0;
`endif

endmodule

// File: doc/regfile_scan_ctrl.md
Name: regfile_scan_ctrl

Overview:
- Diagnostic scan controller for the general and segment register files.
- Accepts dump or load commands from the debug/diagnostic host.
- Freezes the pipeline through a request/acknowledge handshake, then drives the register file serial interface (sEnable/sIn/sOut) word by word.
- Streams words to or from the host over valid/ready channels.
- One instance per register file.

Parameters:
- SIZE, 16, number of register file entries (one scan pass covers all SIZE words).
- WIDTH, `WORD_LENGTH (32), register word width in bits.
- FREEZE_TIMEOUT, 255, clk cycles to wait for freezeAck before aborting.

Ports:
- clk  in  1  system clock; also fed to the register file sClock.
- rst  in  1  reset, synchronous, active-high.
- cmdValid  in  1  host command valid.
- cmdReady  out  1  controller can accept a command (high only in IDLE).
- cmdLoad  in  1  0 = dump (read), 1 = load (write).
- wrValid  in  1  host load word valid.
- wrReady  out  1  controller accepts the load word.
- wrData  in  WIDTH  load word.
- rdValid  out  1  dump word valid.
- rdReady  in  1  host accepts the dump word.
- rdData  out  WIDTH  dump word.
- freezeReq  out  1  request that the pipeline stop register file writes.
- freezeAck  in  1  pipeline confirms it is frozen.
- sEnable  out  1  register file serial shift enable.
- sIn  out  1  serial data into the register file.
- sOut  in  1  serial data from the register file.
- busy  out  1  command in progress.
- error  out  1  sticky; set on freeze timeout, cleared by the next accepted command.
- crc  out  16  scan CRC (see Optional Feature).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State IDLE.
  - All outputs 0 except cmdReady=1.
  - wordCnt=0, bitCnt=0, shift register 0.
- Serial contract:
  - In a cycle with sEnable=1, sOut carries bit bitCnt of the current word, LSB first.
  - The register file captures sIn at that same clk edge.
  - A word takes exactly WIDTH sEnable cycles. Words proceed in address order 0..SIZE-1.
  - Register 0 is scanned like the others; the load value for register 0 is ignored by the register file.
- States:
  - IDLE: cmdReady=1. On cmdValid, latch cmdLoad, clear error and timer, go to FREEZE.
  - FREEZE: freezeReq=1 (held through DONE).
    - On freezeAck: go to LOAD if cmdLoad, else SHIFT.
    - Timer reaches FREEZE_TIMEOUT: set error, drop freezeReq, go to IDLE.
  - LOAD: wrReady=1. On wrValid, capture wrData into the shift register and go to SHIFT.
  - SHIFT: sEnable=1 for WIDTH cycles.
    - Dump: sIn=sOut (loopback, contents preserved); sOut shifted into the MSB of the shift register.
    - Load: sIn = shift register bit 0; shift register shifts right.
    - After WIDTH cycles: dump goes to STORE; load goes to NEXT.
  - STORE: rdValid=1, rdData = captured word (bit k = k-th received bit). Held stable until rdReady, then go to NEXT.
  - NEXT: if wordCnt==SIZE-1, go to DONE; else wordCnt++, bitCnt=0, go to LOAD (load) or SHIFT (dump).
  - DONE: one cycle, freezeReq drops, go to IDLE.
- sEnable is never asserted while waiting in LOAD or STORE (host backpressure stalls the scan without corrupting it).
- Freeze handling:
  - freezeAck deasserting mid-scan is a protocol violation: set error, finish the current word, go to DONE.
  - freezeAck already high on FREEZE entry: leave FREEZE on the next cycle.
- Counters:
  - bitCnt is $clog2(WIDTH)+1 bits wide.
  - wordCnt is $clog2(SIZE) bits wide and wraps to 0 in DONE.
- Latency:
  - Dump of word n: rdValid rises WIDTH+1 cycles after its SHIFT entry.
  - Full dump with rdReady tied high: 2 + SIZE*(WIDTH+2) + 1 cycles from command accept to IDLE.
- rst asserted mid-scan: immediate return to reset state, sEnable=0, freezeReq=0. Partial words in the register file are undefined.

Optional Feature:
- Macro: REGFILE_SCAN_CRC_EN.
- Defined: CRC-16-CCITT (poly 0x1021, init 0xFFFF) updated with each bit on sIn during sEnable cycles.
  - Cleared on command accept.
  - Final value valid from DONE until the next command.
- Undefined: crc tied to 0; no CRC logic instantiated.

Decomposition:
- Shared package regfile_scan_pkg:
  - State enum scan_state_t (IDLE, FREEZE, LOAD, SHIFT, STORE, NEXT, DONE).
  - CRC_POLY, CRC_INIT constants.
  - CMD_DUMP/CMD_LOAD encodings.
- One natural sub-module: scan_crc16, a bit-serial CRC updater, instantiated only under REGFILE_SCAN_CRC_EN.

Test Plan:
- Dump, WIDTH=32, SIZE=16, file preloaded with reg i = 0xA5000000+i, freezeAck one cycle after freezeReq, rdReady=1 → 16 rdData words 0xA5000000..0xA500000F in order; file contents unchanged afterwards; 547 cycles accept-to-IDLE.
- Load of words 0x1000+i → the parallel read port returns reg i = 0x1000+i for i=1..15 and reg 0 = 0.
- Freeze timeout: freezeAck held 0 → error=1 at cycle 256 after accept, freezeReq=0, sEnable never high, cmdReady=1.
- Backpressure: rdReady low for 10 cycles on word 3 → rdData stable, sEnable=0 throughout, remaining words correct.
- rst pulsed during word 5 of a load → next cycle all outputs at reset values; a subsequent dump completes normally.
- With REGFILE_SCAN_CRC_EN, dump of an all-zero file → crc equals the reference CRC-16-CCITT of 512 zero bits; without the macro, crc=0.
